// File: rtl/division_unit_pkg.sv
// Shared definitions for the restoring divider: FSM encodings, control-vector widths, constants.
// The signed variant is selected with the DIVIDER_SIGNED_EN macro in the sub-files.
package division_unit_pkg;

  // Field widths shared with the multiplier controller.
  localparam int CTRL_STATE_W  = 3;
  localparam int CTRL_STROBE_W = 4;

  typedef enum logic [CTRL_STATE_W-1:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    TEST   = 3'd3,
    FINISH = 3'd4
  } div_state_e;

  localparam int STROBE_LOAD   = 0;
  localparam int STROBE_SHIFT  = 1;
  localparam int STROBE_TEST   = 2;
  localparam int STROBE_FINISH = 3;

  // Sliced down to WIDTH by the datapath.
  localparam logic [15:0] DIV0_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/division_datapath.sv
// Restoring-divider datapath: R/Q/D registers, compare/subtract and result registers.
// With DIVIDER_SIGNED_EN defined, operands are two's complement and signs are fixed up on Finish entry.
module division_datapath
  import division_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             test_i,
  input  logic             finish_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic             r_ge;
  logic [WIDTH:0]   r_test;
  logic [WIDTH-1:0] q_test;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign div_zero_o = (divisor_i == '0);

  assign r_ge   = (r_q >= {1'b0, d_q});
  // Restore by keeping the old R when the trial subtraction would go negative.
  assign r_test = r_ge ? (r_q - {1'b0, d_q}) : r_q;
  assign q_test = {q_q[WIDTH-1:1], r_ge};

`ifdef DIVIDER_SIGNED_EN
  logic neg_q_q;
  logic neg_r_q;

  assign dividend_mag = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign divisor_mag  = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
  // Most-negative / -1 yields a magnitude that negates back onto itself.
  assign q_fix = neg_q_q ? -q_test : q_test;
  assign r_fix = neg_r_q ? -r_test[WIDTH-1:0] : r_test[WIDTH-1:0];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (load_i) begin
      neg_q_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
      neg_r_q <= dividend_i[WIDTH-1];
    end
  end
`else
  assign dividend_mag = dividend_i;
  assign divisor_mag  = divisor_i;
  assign q_fix        = q_test;
  assign r_fix        = r_test[WIDTH-1:0];
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_q           <= '0;
      q_q           <= '0;
      d_q           <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else if (load_i) begin
      r_q <= '0;
      q_q <= dividend_mag;
      d_q <= divisor_mag;
      // A zero divisor skips the iterations, so results are written straight from the inputs.
      if (div_zero_o) begin
        quotient_o    <= DIV0_QUOTIENT[WIDTH-1:0];
        remainder_o   <= dividend_i;
        div_by_zero_o <= 1'b1;
      end
    end else if (shift_i) begin
      {r_q, q_q} <= {r_q[WIDTH-1:0], q_q, 1'b0};
    end else if (test_i) begin
      r_q <= r_test;
      q_q <= q_test;
      if (finish_i) begin
        quotient_o    <= q_fix;
        remainder_o   <= r_fix;
        div_by_zero_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/division_unit.sv
// Sequential restoring divider top: Idle/Load/Shift/Test/Finish controller around division_datapath.
// Define DIVIDER_SIGNED_EN for two's-complement operands; default build is unsigned.
module division_unit
  import division_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e               state_q;
  logic [CNT_W-1:0]         count_q;
  logic                     last_iter;
  logic                     div_zero;
  logic [CTRL_STROBE_W-1:0] strobe;

  assign last_iter = (count_q == CNT_W'(WIDTH - 1));

  assign strobe[STROBE_LOAD]   = (state_q == LOAD);
  assign strobe[STROBE_SHIFT]  = (state_q == SHIFT);
  assign strobe[STROBE_TEST]   = (state_q == TEST);
  assign strobe[STROBE_FINISH] = (state_q == TEST) && last_iter;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            state_q <= LOAD;
            Busy    <= 1'b1;
          end
        end
        LOAD: begin
          count_q <= '0;
          if (div_zero) begin
            state_q <= FINISH;
            Done    <= 1'b1;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: state_q <= TEST;
        TEST: begin
          count_q <= count_q + CNT_W'(1);
          if (last_iter) begin
            state_q <= FINISH;
            Done    <= 1'b1;
          end else begin
            state_q <= SHIFT;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          Busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

  division_datapath #(.WIDTH(WIDTH)) u_datapath (
    .Clock         (Clock),
    .Reset         (Reset),
    .load_i        (strobe[STROBE_LOAD]),
    .shift_i       (strobe[STROBE_SHIFT]),
    .test_i        (strobe[STROBE_TEST]),
    .finish_i      (strobe[STROBE_FINISH]),
    .dividend_i    (Dividend),
    .divisor_i     (Divisor),
    .div_zero_o    (div_zero),
    .quotient_o    (Quotient),
    .remainder_o   (Remainder),
    .div_by_zero_o (DivByZero)
  );

endmodule

// File: tb/tb_division_unit.sv
// Directed self-checking bench for division_unit (WIDTH=4); signed vectors when DIVIDER_SIGNED_EN is defined.
module tb_division_unit;

  localparam int W = 4;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         DivByZero;

  int evaluated = 0;
  int failures  = 0;

  division_unit #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s: observed %0d expected %0d", tag, what, obs, exp);
    end
  endtask

  // Present operands with Start for one edge; returns at the negedge of cycle 1 (Load).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clock);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Counts cycles from cycle 1 until Done; optionally pulses Start in cycles 3-4 and in Finish.
  task automatic wait_done(input bit pulse, output int n, output bit busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (Done !== 1'b1 && n < 40) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (pulse) Start = (n == 3 || n == 4);
      @(negedge Clock);
      n++;
    end
    if (Busy !== 1'b1) busy_ok = 1'b0;
    if (pulse) Start = 1'b1;
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input int elat, input bit pulse);
    int n;
    bit busy_ok;
    launch(a, b);
    wait_done(pulse, n, busy_ok);
    check(tag, "latency", n, elat);
    check(tag, "busy_during", {31'd0, busy_ok}, 32'd1);
    check(tag, "quotient", {28'd0, Quotient}, {28'd0, eq});
    check(tag, "remainder", {28'd0, Remainder}, {28'd0, er});
    check(tag, "divbyzero", {31'd0, DivByZero}, {31'd0, edz});
    @(negedge Clock);
    Start = 1'b0;
    check(tag, "done_one_cycle", {31'd0, Done}, 32'd0);
    check(tag, "busy_after", {31'd0, Busy}, 32'd0);
    $display("div %s: %0d / %0d -> q=%0d r=%0d dz=%0d after %0d cycles", tag, a, b, Quotient, Remainder, DivByZero, n);
  endtask

  initial begin
    int n;
    int n2;
    int extra_done;
    bit busy_ok;
    logic busy_gap;

    Reset    = 1'b0;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (2) @(negedge Clock);
    check("reset", "quotient", {28'd0, Quotient}, 32'd0);
    check("reset", "remainder", {28'd0, Remainder}, 32'd0);
    check("reset", "busy", {31'd0, Busy}, 32'd0);
    check("reset", "done", {31'd0, Done}, 32'd0);
    check("reset", "divbyzero", {31'd0, DivByZero}, 32'd0);
    Reset = 1'b1;
    @(negedge Clock);

`ifdef DIVIDER_SIGNED_EN
    run_div("s_m7_2", 4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 10, 1'b0);
    run_div("s_7_m2", 4'd7, 4'b1110, 4'b1101, 4'd1, 1'b0, 10, 1'b0);
    run_div("s_m8_m1", 4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0, 10, 1'b0);
    run_div("s_6_3", 4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 10, 1'b0);
    run_div("s_m7_0", 4'b1001, 4'd0, 4'b1111, 4'b1001, 1'b1, 2, 1'b0);
    run_div("s_m6_m4", 4'b1010, 4'b1100, 4'd1, 4'b1110, 1'b0, 10, 1'b0);
`else
    run_div("u_13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 10, 1'b0);

    // Back-to-back with Start held high across both operations.
    @(negedge Clock);
    Dividend = 4'd15;
    Divisor  = 4'd1;
    Start    = 1'b1;
    @(negedge Clock);
    wait_done(1'b0, n, busy_ok);
    check("b2b_first", "latency", n, 10);
    check("b2b_first", "quotient", {28'd0, Quotient}, 32'd15);
    check("b2b_first", "remainder", {28'd0, Remainder}, 32'd0);
    $display("div b2b_first: 15 / 1 -> q=%0d r=%0d after %0d cycles", Quotient, Remainder, n);
    Dividend = 4'd5;
    Divisor  = 4'd7;
    n2 = 0;
    busy_gap = 1'b1;
    do begin
      @(negedge Clock);
      n2++;
      if (n2 == 1) busy_gap = Busy;
    end while (Done !== 1'b1 && n2 < 40);
    Start = 1'b0;
    check("b2b_second", "done_spacing", n2, 11);
    check("b2b_second", "idle_gap_busy", {31'd0, busy_gap}, 32'd0);
    check("b2b_second", "quotient", {28'd0, Quotient}, 32'd0);
    check("b2b_second", "remainder", {28'd0, Remainder}, 32'd5);
    $display("div b2b_second: 5 / 7 -> q=%0d r=%0d after %0d cycles", Quotient, Remainder, n2);
    @(negedge Clock);

    run_div("u_9_0", 4'd9, 4'd0, 4'b1111, 4'd9, 1'b1, 2, 1'b0);
    run_div("u_15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 10, 1'b0);
    run_div("u_2_15", 4'd2, 4'd15, 4'd0, 4'd2, 1'b0, 10, 1'b0);

    // Start pulses in Shift/Test/Finish must not disturb or relaunch.
    run_div("u_14_4_pulse", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 10, 1'b1);
    extra_done = 0;
    repeat (14) begin
      @(negedge Clock);
      if (Done === 1'b1) extra_done++;
    end
    check("pulse_ignored", "extra_done", extra_done, 0);
    check("pulse_ignored", "quotient_held", {28'd0, Quotient}, 32'd3);
    check("pulse_ignored", "remainder_held", {28'd0, Remainder}, 32'd2);
    $display("div pulse_ignored: extra Done count %0d", extra_done);

    // Reset in the middle of Test (cycle 3), then a clean operation.
    launch(4'd13, 4'd3);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("mid_reset", "quotient", {28'd0, Quotient}, 32'd0);
    check("mid_reset", "remainder", {28'd0, Remainder}, 32'd0);
    check("mid_reset", "busy", {31'd0, Busy}, 32'd0);
    check("mid_reset", "done", {31'd0, Done}, 32'd0);
    check("mid_reset", "divbyzero", {31'd0, DivByZero}, 32'd0);
    $display("div mid_reset: outputs q=%0d r=%0d busy=%0d", Quotient, Remainder, Busy);
    @(negedge Clock);
    Reset = 1'b1;
    run_div("u_12_4", 4'd12, 4'd4, 4'd3, 4'd0, 1'b0, 10, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
